// File: rtl/fetch_pc_gen_pkg.sv
// fetch_pkg: shared constants and types for the fetch PC generator
//   FETCH_RESET_PC   default PC loaded into every thread on reset
//   tid_t            widest thread id (8 threads), for tracing
//   redirect_cause_e winning redirect source per thread
package fetch_pkg;
    localparam logic [31:0] FETCH_RESET_PC = 32'h6000_0000;
    localparam int MAX_TID_W = 3;
    typedef logic [MAX_TID_W-1:0] tid_t;
    typedef enum logic [2:0] {RD_NONE, RD_JAL, RD_JALR, RD_BR, RD_FLUSH} redirect_cause_e;
endpackage

// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch-block request handshake to the I-cache/fetch queue
//   valid  block request valid          (master -> slave)
//   tid    thread of request            (master -> slave)
//   pc     PC of first valid slot       (master -> slave)
//   mask   valid slots, bit i = slot i  (master -> slave)
//   ready  consumer accepts this cycle  (slave -> master)
interface fetch_pc_gen_if #(
    parameter int TID_W       = 1,
    parameter int FETCH_WIDTH = 1
);
    logic                   valid;
    logic                   ready;
    logic [TID_W-1:0]       tid;
    logic [31:0]            pc;
    logic [FETCH_WIDTH-1:0] mask;
    modport master (output valid, tid, pc, mask, input ready);
    modport slave  (input valid, tid, pc, mask, output ready);
endinterface

// File: rtl/fetch_pc_gen_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req        request vector
//   ptr        highest-priority index this cycle
//   gnt_valid  any request present
//   gnt_idx    granted index
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);
    logic [N-1:0] rot;

    // rot[i] is the request i positions after ptr
    assign rot = N'({req, req} >> ptr);

    // scanned downwards so the closest request to ptr wins
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'((int'(ptr) + i) % N);
            end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: multi-thread fetch PC generator with round-robin thread select and prioritized redirects
//   clk, rst                  clock, synchronous active-high reset
//   thread_en / thread_stall  per-thread enable and back-pressure
//   fetch                     request handshake (valid/ready/tid/pc/mask)
//   flush_*, br_*, jalr_*, jal_*  redirects, priority flush > br > jalr > jal
//   last_pc                   PC of last accepted block per thread, thread t at [t*32 +: 32]
//   misalign_err/misalign_tid registered misaligned-target report (FETCH_PC_MISALIGN_CHECK_EN)
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int          NUM_THREADS = 2,
    parameter int          FETCH_WIDTH = 1,
    parameter logic [31:0] RESET_PC    = FETCH_RESET_PC,
    parameter int          TID_W       = NUM_THREADS > 1 ? $clog2(NUM_THREADS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic [NUM_THREADS-1:0]   thread_stall,
    fetch_pc_gen_if.master           fetch,
    input  logic                     flush_valid,
    input  logic [TID_W-1:0]         flush_tid,
    input  logic [31:0]              flush_pc,
    input  logic                     br_valid,
    input  logic [TID_W-1:0]         br_tid,
    input  logic [31:0]              br_pc,
    input  logic                     jalr_valid,
    input  logic [TID_W-1:0]         jalr_tid,
    input  logic [31:0]              jalr_pc,
    input  logic                     jal_valid,
    input  logic [TID_W-1:0]         jal_tid,
    input  logic [31:0]              jal_pc,
`ifdef FETCH_PC_MISALIGN_CHECK_EN
    output logic                     misalign_err,
    output logic [TID_W-1:0]         misalign_tid,
`endif
    output logic [NUM_THREADS*32-1:0] last_pc
);
    localparam logic [31:0] BLK = 32'(4 * FETCH_WIDTH);
`ifdef FETCH_PC_MISALIGN_CHECK_EN
    localparam logic [31:0] LOAD_MASK = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] LOAD_MASK = 32'hFFFF_FFFF;
`endif

    logic [31:0]            pc_q [NUM_THREADS];
    logic [31:0]            tgt  [NUM_THREADS];
    redirect_cause_e        cause [NUM_THREADS];
    logic [NUM_THREADS-1:0] hit;
    logic [NUM_THREADS-1:0] elig;
    logic [TID_W-1:0]       rr_ptr;
    logic [TID_W-1:0]       sel;
    logic                   gnt;
    logic                   accept;
    logic [31:0]            cur_pc;
    logic [FETCH_WIDTH-1:0] mask;

    // out-of-range tids never match any t, so they are ignored
    always_comb
        for (int t = 0; t < NUM_THREADS; t++) begin
            cause[t] = flush_valid && int'(flush_tid) == t ? RD_FLUSH :
                       br_valid    && int'(br_tid)    == t ? RD_BR    :
                       jalr_valid  && int'(jalr_tid)  == t ? RD_JALR  :
                       jal_valid   && int'(jal_tid)   == t ? RD_JAL   : RD_NONE;
            tgt[t]   = cause[t] == RD_FLUSH ? flush_pc :
                       cause[t] == RD_BR    ? br_pc    :
                       cause[t] == RD_JALR  ? jalr_pc  : jal_pc;
            hit[t]   = cause[t] != RD_NONE;
        end

    // a redirected thread sits out this cycle so its stale PC is never issued
    assign elig = thread_en & ~thread_stall & ~hit;

    rr_arbiter #(.N(NUM_THREADS), .IDX_W(TID_W)) u_arb (
        .req       (elig),
        .ptr       (rr_ptr),
        .gnt_valid (gnt),
        .gnt_idx   (sel)
    );

    assign cur_pc = pc_q[sel];

    always_comb begin
        mask = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            mask[i] = i >= int'((cur_pc >> 2) & 32'(FETCH_WIDTH - 1));
    end

    // idle outputs are parked at fixed values
    assign fetch.valid = gnt & ~rst;
    assign fetch.tid   = fetch.valid ? sel : '0;
    assign fetch.pc    = fetch.valid ? cur_pc : RESET_PC;
    assign fetch.mask  = fetch.valid ? mask : '0;
    assign accept      = fetch.valid & fetch.ready;

`ifdef FETCH_PC_MISALIGN_CHECK_EN
    logic             mis_any;
    logic [TID_W-1:0] mis_tid;

    // lowest misaligned thread is reported when several hit together
    always_comb begin
        mis_any = 1'b0;
        mis_tid = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--)
            if (hit[t] && tgt[t][1:0] != 2'b00) begin
                mis_any = 1'b1;
                mis_tid = TID_W'(t);
            end
    end

    always_ff @(posedge clk)
        if (rst) begin
            misalign_err <= 1'b0;
            misalign_tid <= '0;
        end else begin
            misalign_err <= mis_any;
            misalign_tid <= mis_tid;
        end
`endif

    always_ff @(posedge clk)
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t]              <= RESET_PC;
                last_pc[t*32 +: 32]  <= RESET_PC;
            end
            rr_ptr <= '0;
        end else begin
            // a redirected thread is never the accepted one, so the branches are exclusive
            for (int t = 0; t < NUM_THREADS; t++)
                if (hit[t])
                    pc_q[t] <= tgt[t] & LOAD_MASK;
                else if (accept && int'(sel) == t) begin
                    pc_q[t]             <= (cur_pc & ~(BLK - 32'd1)) + BLK;
                    last_pc[t*32 +: 32] <= cur_pc;
                end
            if (accept)
                rr_ptr <= TID_W'((int'(sel) + 1) % NUM_THREADS);
        end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen against a behavioural thread/PC model
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    localparam int          N   = 2;
    localparam int          FW  = 2;
    localparam int          TW  = 1;
    localparam logic [31:0] RPC = 32'h6000_0000;
    localparam int          BLK = 4 * FW;

    typedef struct {
        logic [TW-1:0] tid;
        logic [31:0]   pc;
        logic [FW-1:0] mask;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       en = '0;
    logic [N-1:0]       stall = '0;
    logic [3:0]         rv = '0;
    logic [3:0][TW-1:0] rt = '0;
    logic [3:0][31:0]   rp = '0;
    logic [N*32-1:0]    last_pc;
`ifdef FETCH_PC_MISALIGN_CHECK_EN
    logic               merr;
    logic [TW-1:0]      mtid;
`endif

    fetch_pc_gen_if #(.TID_W(TW), .FETCH_WIDTH(FW)) fif ();

    fetch_pc_gen #(.NUM_THREADS(N), .FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .thread_en    (en),
        .thread_stall (stall),
        .fetch        (fif),
        .flush_valid  (rv[0]), .flush_tid (rt[0]), .flush_pc (rp[0]),
        .br_valid     (rv[1]), .br_tid    (rt[1]), .br_pc    (rp[1]),
        .jalr_valid   (rv[2]), .jalr_tid  (rt[2]), .jalr_pc  (rp[2]),
        .jal_valid    (rv[3]), .jal_tid   (rt[3]), .jal_pc   (rp[3]),
`ifdef FETCH_PC_MISALIGN_CHECK_EN
        .misalign_err (merr),
        .misalign_tid (mtid),
`endif
        .last_pc      (last_pc)
    );

    always #5 clk = ~clk;

    logic [31:0] m_pc [N];
    logic [31:0] m_last [N];
    int          m_rr;
    bit          m_err;
    int          m_etid;
    exp_t        q [$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    bit          armed = 0;
    bit          cur_v;
    int          cur_sel;

    // index of the winning redirect for thread t (0 flush .. 3 jal), -1 if none
    function automatic int redirect_of(int t);
        for (int k = 0; k < 4; k++)
            if (rv[k] && int'(rt[k]) == t) return k;
        return -1;
    endfunction

    // expectation for the current inputs, one clock, then model state advance
    task automatic tick();
        exp_t e;
        int   slot;
        logic [31:0] tg;
        cur_v   = 0;
        cur_sel = 0;
        if (!rst)
            for (int k = 0; k < N; k++)
                if (!cur_v && en[(m_rr + k) % N] && !stall[(m_rr + k) % N] && redirect_of((m_rr + k) % N) < 0) begin
                    cur_v   = 1;
                    cur_sel = (m_rr + k) % N;
                end
        if (cur_v) begin
            e.tid  = TW'(cur_sel);
            e.pc   = m_pc[cur_sel];
            slot   = int'((e.pc >> 2) % FW);
            e.mask = FW'((1 << FW) - (1 << slot));
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int t = 0; t < N; t++) begin
                m_pc[t]   = RPC;
                m_last[t] = RPC;
            end
            m_rr  = 0;
            m_err = 0;
        end else begin
            m_err = 0;
            if (cur_v && fif.ready) begin
                m_last[cur_sel] = m_pc[cur_sel];
                m_pc[cur_sel]   = m_pc[cur_sel] - (m_pc[cur_sel] % BLK) + BLK;
                m_rr            = (cur_sel + 1) % N;
            end
            for (int t = 0; t < N; t++)
                if (redirect_of(t) >= 0) begin
                    tg = rp[redirect_of(t)];
`ifdef FETCH_PC_MISALIGN_CHECK_EN
                    if (tg[1:0] != 2'b00 && !m_err) begin
                        m_err  = 1;
                        m_etid = t;
                    end
                    tg[1:0] = 2'b00;
`endif
                    m_pc[t] = tg;
                end
        end
    endtask

    task automatic redir(input int k, input int tid, input logic [31:0] pc);
        rv[k] = 1'b1;
        rt[k] = TW'(tid);
        rp[k] = pc;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (rst || !fif.valid) begin
                checks++;
                if (fif.valid !== 1'b0 || fif.pc !== RPC || fif.mask !== '0 || fif.tid !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs: got valid=%b tid=%0d pc=%h mask=%b, want valid=0 tid=0 pc=%h mask=0",
                             fif.valid, fif.tid, fif.pc, fif.mask, RPC);
                end
            end
            if (!rst && fif.valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got tid=%0d pc=%h with nothing expected", fif.tid, fif.pc);
                end else begin
                    me = q.pop_front();
                    if (fif.tid !== me.tid || fif.pc !== me.pc || fif.mask !== me.mask) begin
                        errors++;
                        $display("FAIL fetch_req: got tid=%0d pc=%h mask=%b, want tid=%0d pc=%h mask=%b",
                                 fif.tid, fif.pc, fif.mask, me.tid, me.pc, me.mask);
                    end
                end
            end
            for (int t = 0; t < N; t++) begin
                checks++;
                if (last_pc[t*32 +: 32] !== m_last[t]) begin
                    errors++;
                    $display("FAIL last_pc[%0d]: got %h, want %h", t, last_pc[t*32 +: 32], m_last[t]);
                end
            end
`ifdef FETCH_PC_MISALIGN_CHECK_EN
            checks++;
            if (merr !== m_err || (m_err && int'(mtid) != m_etid)) begin
                errors++;
                $display("FAIL misalign: got err=%b tid=%0d, want err=%b tid=%0d", merr, mtid, m_err, m_etid);
            end
`endif
        end
    end

    initial begin
        fif.ready = 1'b0;
        @(posedge clk);
        #1;
        for (int t = 0; t < N; t++) begin
            m_pc[t]   = RPC;
            m_last[t] = RPC;
        end
        m_rr  = 0;
        m_err = 0;
        armed = 1;
        tick();
        rst = 1'b0; en = 2'b01; fif.ready = 1'b1;
        repeat (3) tick();
        redir(1, 0, 32'h6000_0104);
        tick();
        rv = '0;
        repeat (3) tick();
        redir(0, 0, 32'h6000_0200);
        redir(1, 0, 32'h6000_0300);
        tick();
        rv = '0;
        repeat (2) tick();
        en = 2'b11;
        redir(2, 0, 32'h6000_0400);
        redir(3, 1, 32'h6000_0500);
        tick();
        rv = '0;
        repeat (4) tick();
        fif.ready = 1'b0;
        repeat (3) tick();
        fif.ready = 1'b1;
        repeat (2) tick();
        stall = 2'b01;
        repeat (3) tick();
        stall = 2'b00;
        repeat (3) tick();
        redir(3, 1, 32'h6000_0012);
        tick();
        rv = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        redir(0, 0, 32'hFFFF_FFFC);
        tick();
        rv = '0;
        repeat (3) tick();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            en        = N'($urandom);
            stall     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            fif.ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                rv[k] = ($urandom_range(0, 7) == 0);
                rt[k] = TW'($urandom);
                rp[k] = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : (RPC | (32'($urandom) & 32'hFFF));
            end
            tick();
        end
        rst = 1'b0;
        rv  = '0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d requests never issued, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
